// File: rtl/mem_port_arbiter.sv
// Shares the core's single-port RAM between fetch (I) and load/store (D).
// Optional address check enabled by MEM_PORT_ARBITER_CHECK_EN.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_wd,
  input  logic [DATA_W-1:0] ram_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  if (MEM_BYTES < 4 || MEM_BYTES % 4 != 0) begin : g_mem_bytes_chk
    $error("MEM_BYTES must be a positive multiple of 4");
  end

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic              is_store;
  logic              gnt_any;
  logic              gnt_d;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_bad;
  logic              rej;

  // owner/last_grant: 1 = D, 0 = I
  always_comb begin
    gnt_any  = i_req | d_req;
    gnt_d    = d_req & (~i_req | ~last_grant);
    gnt_addr = gnt_d ? d_addr : i_addr;
  end

`ifdef MEM_PORT_ARBITER_CHECK_EN
  logic err_q;
  assign gnt_bad = (gnt_addr[1:0] != 2'b00) ||
                   (gnt_addr >= ADDR_W'(MEM_BYTES));
  assign err     = err_q;
`else
  assign gnt_bad = 1'b0;
  assign rej     = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      is_store   <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      busy       <= 1'b0;
      ram_we     <= 1'b0;
      ram_a      <= '0;
      ram_wd     <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
`ifdef MEM_PORT_ARBITER_CHECK_EN
      rej        <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
`ifdef MEM_PORT_ARBITER_CHECK_EN
      err_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            owner      <= gnt_d;
            last_grant <= gnt_d;
            ram_a      <= gnt_addr;
            ram_wd     <= d_wdata;
            ram_we     <= gnt_d & d_we & ~gnt_bad;
            is_store   <= gnt_d & d_we;
            busy       <= 1'b1;
            state      <= ACCESS;
`ifdef MEM_PORT_ARBITER_CHECK_EN
            rej        <= gnt_bad;
`endif
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          if (!is_store && !rej) begin
            if (owner) d_rdata <= ram_rd;
            else       i_rdata <= ram_rd;
          end
          if (owner) d_ack <= 1'b1;
          else       i_ack <= 1'b1;
`ifdef MEM_PORT_ARBITER_CHECK_EN
          err_q <= rej;
`endif
          state <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a word-level RAM model.
// Honours MEM_PORT_ARBITER_CHECK_EN when defined.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 128;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          err;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_wd;
  logic [DW-1:0] ram_rd = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .busy(busy),
    .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side RAM with registered read, word-indexed by byte address
  logic [31:0] ram [32];
  always @(posedge clk) begin
    if (ram_we) ram[ram_a[6:2]] <= ram_wd;
    ram_rd <= ram[ram_a[6:2]];
  end

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
    bit          err;
  } exp_t;
  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  exp_t exp_q[$];
  st_t  st_q[$];

  logic [31:0] mdl [32];
  logic [31:0] m_ird, m_drd;
  bit          m_lg;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    bit r = 0;
`ifdef MEM_PORT_ARBITER_CHECK_EN
    r = (a[1:0] != 2'b00) || (a >= MB);
`endif
    return r;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a = 32'($urandom_range(0, 31)) * 4;
`ifdef MEM_PORT_ARBITER_CHECK_EN
    if ($urandom_range(0, 7) == 0)
      a = $urandom_range(0, 1) ? a + 2 : a + 32'h80;
`endif
    return a;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    st_t  s;
    if (mon_en) begin
      if (i_ack || d_ack) begin
        chk("ack_exclusive", {31'b0, i_ack & d_ack}, 32'd0);
        chk("busy_resp", {31'b0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {31'b0, d_ack}, {31'b0, e.port});
          chk("ack_cycle", cyc, e.cyc);
          chk("rdata", e.port ? d_rdata : i_rdata, e.data);
          chk("err", {31'b0, err}, {31'b0, e.err});
        end
      end
      if (ram_we) begin
        if (st_q.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          s = st_q.pop_front();
          chk("we_cycle", cyc, s.cyc);
          chk("we_addr", ram_a, s.a);
          chk("we_data", ram_wd, s.d);
        end
      end
    end
  end

  // Model the service order, push expectations, then drive and wait.
  task automatic txn(input bit iv, input bit dv, input bit dwe,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] wd, input logic [31:0] alt);
    int c;
    int n;
    bit ord[2];
    bit b;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    c = cyc;
    n = 0;
    if (iv && dv) begin
      ord[0] = !m_lg;
      ord[1] = m_lg;
      n = 2;
    end else if (iv) begin
      ord[0] = 0;
      n = 1;
    end else if (dv) begin
      ord[0] = 1;
      n = 1;
    end
    for (int k = 0; k < n; k++) begin
      if (!ord[k]) begin
        b = bad(ia);
        if (!b) m_ird = mdl[ia[6:2]];
        exp_q.push_back('{0, m_ird, c + 4 * k + 3, b});
      end else begin
        b = bad(da);
        if (dwe) begin
          if (!b) begin
            mdl[da[6:2]] = wd;
            st_q.push_back('{c + 4 * k + 1, da, wd});
          end
        end else if (!b) begin
          m_drd = mdl[da[6:2]];
        end
        exp_q.push_back('{1, m_drd, c + 4 * k + 3, b});
      end
      m_lg = ord[k];
    end
    i_req = iv;
    i_addr = ia;
    d_req = dv;
    d_we = dwe;
    d_addr = da;
    d_wdata = wd;
    for (int t = 0; t < 12 && (i_req || d_req); t++) begin
      @(negedge clk);
      if (cyc == c + 1 && n > 0) begin
        if (ord[0]) begin
          d_addr = alt;
          d_we = 1'($urandom);
          d_wdata = $urandom;
        end else begin
          i_addr = alt;
        end
      end
      if (i_ack) i_req = 0;
      if (d_ack) d_req = 0;
    end
    if (i_req || d_req) begin
      chk("txn_timeout", 32'd1, 32'd0);
      i_req = 0;
      d_req = 0;
    end
  endtask

  task automatic model_reset();
    m_lg = 1;
    m_ird = '0;
    m_drd = '0;
  endtask

  initial begin
    int c;
    int nbad;
    bit iv, dv;
    for (int i = 0; i < 32; i++) mdl[i] = $urandom;
    mdl[0] = 32'h0000_0293;
    mdl[10] = 32'hfd9f_f06f;
    for (int i = 0; i < 32; i++) ram[i] = mdl[i];
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wd", ram_wd, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    resetn = 1;
    mon_en = 1;

    txn(1, 0, 0, 32'h00, 32'h00, 32'h0, 32'h40);
    txn(0, 1, 1, 32'h00, 32'h3C, 32'h1, 32'h20);
    txn(0, 1, 0, 32'h00, 32'h3C, 32'h0, 32'h00);
    txn(0, 1, 0, 32'h00, 32'h28, 32'h0, 32'h04);

    for (int r = 0; r < 60; r++) begin
      iv = 1'($urandom);
      dv = 1'($urandom);
      if (!iv && !dv) iv = 1;
      txn(iv, dv, 1'($urandom), rnd_addr(), rnd_addr(), $urandom,
          rnd_addr());
    end

`ifdef MEM_PORT_ARBITER_CHECK_EN
    txn(0, 1, 1, 32'h00, 32'h3E, $urandom, 32'h00);
    txn(0, 1, 0, 32'h00, 32'h80, 32'h0, 32'h00);
`endif

    @(negedge clk);
    c = cyc;
    i_req = 1;
    i_addr = 32'h8;
    while (cyc < c + 2) @(negedge clk);
    resetn = 0;
    @(negedge clk);
    chk("midrst_i_ack", {31'b0, i_ack}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_ram_we", {31'b0, ram_we}, 32'd0);
    i_req = 0;
    resetn = 1;
    model_reset();

    txn(1, 1, 0, 32'h10, 32'h14, 32'h0, 32'h30);
    txn(1, 1, 1, 32'h18, 32'h18, $urandom, 32'h00);
    txn(1, 0, 0, 32'h18, 32'h00, 32'h0, 32'h04);

    repeat (6) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("st_q_empty", st_q.size(), 32'd0);
    nbad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== mdl[i]) nbad++;
    chk("ram_contents", nbad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
